// File: rtl/dispatch_queue_if.sv
// dispatch_queue_if: decode-side group input and two-lane issue output of the dispatch queue
interface dispatch_queue_if #(parameter int DEPTH = 16, parameter int UOP_W = 64);
  localparam int CW = $clog2(DEPTH) + 1;
  logic               flush;
  logic [4*UOP_W-1:0] uop_4W_in;
  logic [3:0]         uop_4W_valid_in;
  logic [27:0]        uop_4W_pc_in;
  logic               pre_valid;
  logic               out_ready;
  logic [UOP_W-1:0]   issue_uop0;
  logic [31:0]        issue_pc0;
  logic               issue_valid0;
  logic [UOP_W-1:0]   issue_uop1;
  logic [31:0]        issue_pc1;
  logic               issue_valid1;
  logic [1:0]         issue_ack;
  logic [CW-1:0]      count;
  modport master (
    output flush, uop_4W_in, uop_4W_valid_in, uop_4W_pc_in, pre_valid, issue_ack,
    input  out_ready, issue_uop0, issue_pc0, issue_valid0, issue_uop1, issue_pc1, issue_valid1, count
  );
  modport slave (
    input  flush, uop_4W_in, uop_4W_valid_in, uop_4W_pc_in, pre_valid, issue_ack,
    output out_ready, issue_uop0, issue_pc0, issue_valid0, issue_uop1, issue_pc1, issue_valid1, count
  );
endinterface

// File: rtl/dispatch_queue.sv
// dispatch_queue: compacting 4-wide in-order circular queue feeding two issue lanes
module dispatch_queue #(
  parameter int DEPTH = 16,
  parameter int UOP_W = 64
) (
  input logic             clk,
  input logic             rst,
  dispatch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = UOP_W + 32;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq;
  logic [2:0]    n_enq;
  logic [2:0]    off [4];
  logic [1:0]    n_deq;
  logic [EW-1:0] e0, e1;
  // off[i] is the number of valid slots below slot i, i.e. its compacted position
  always_comb begin
    n_enq = '0;
    for (int i = 0; i < 4; i++) begin
      off[i] = n_enq;
      n_enq = n_enq + {2'b0, q.uop_4W_valid_in[i]};
    end
  end
  always_comb begin
    enq = q.pre_valid && q.out_ready && !q.flush;
    n_deq = (q.issue_ack[0] && count_q != '0) ? ((q.issue_ack[1] && count_q >= CW'(2)) ? 2'd2 : 2'd1) : 2'd0;
    head_d = q.flush ? '0 : head_q + AW'(n_deq);
    tail_d = q.flush ? '0 : enq ? tail_q + AW'(n_enq) : tail_q;
    count_d = q.flush ? '0 : count_q + (enq ? CW'(n_enq) : '0) - CW'(n_deq);
  end
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < 4; i++)
      if (enq && q.uop_4W_valid_in[i])
        mem_d[tail_q + AW'(off[i])] = {q.uop_4W_in[i*UOP_W +: UOP_W], q.uop_4W_pc_in, 2'(i), 2'b00};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign e0 = mem_q[head_q];
  assign e1 = mem_q[head_q + AW'(1)];
  assign q.out_ready    = count_q <= CW'(DEPTH - 4);
  assign q.issue_valid0 = count_q != '0;
  assign q.issue_valid1 = count_q >= CW'(2);
  assign q.issue_uop0   = q.issue_valid0 ? e0[EW-1:32] : '0;
  assign q.issue_pc0    = q.issue_valid0 ? e0[31:0] : '0;
  assign q.issue_uop1   = q.issue_valid1 ? e1[EW-1:32] : '0;
  assign q.issue_pc1    = q.issue_valid1 ? e1[31:0] : '0;
  assign q.count        = count_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: queue-model scoreboard checked every cycle plus directed literal checks
module tb_dispatch_queue;
  localparam int DEPTH = 16;
  localparam int UOP_W = 64;
  typedef struct {
    logic [63:0] uop;
    logic [31:0] pc;
  } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dispatch_queue_if #(.DEPTH(DEPTH), .UOP_W(UOP_W)) bus ();
  dispatch_queue #(.DEPTH(DEPTH), .UOP_W(UOP_W)) dut (.clk(clk), .rst(rst), .q(bus));
  ent_t mq[$];
  int checks = 0;
  int errors = 0;
  bit live = 1'b0;
  int g = 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    int sz, k;
    if (rst || bus.flush) mq.delete();
    else begin
      sz = mq.size();
      k = (bus.issue_ack == 2'b11) ? 2 : (bus.issue_ack == 2'b01) ? 1 : 0;
      if (k > sz) k = sz;
      if (bus.pre_valid && DEPTH - sz >= 4)
        for (int i = 0; i < 4; i++)
          if (bus.uop_4W_valid_in[i])
            mq.push_back('{bus.uop_4W_in[i*UOP_W +: UOP_W], {bus.uop_4W_pc_in, 4'h0} + 32'(4 * i)});
      repeat (k) void'(mq.pop_front());
    end
  end
  always @(negedge clk) begin
    int n;
    if (live) begin
      n = mq.size();
      chk("count", 64'(bus.count), 64'(n));
      chk("out_ready", 64'(bus.out_ready), 64'(DEPTH - n >= 4));
      chk("valid0", 64'(bus.issue_valid0), 64'(n >= 1));
      chk("valid1", 64'(bus.issue_valid1), 64'(n >= 2));
      chk("uop0", bus.issue_uop0, n >= 1 ? mq[0].uop : 64'h0);
      chk("pc0", 64'(bus.issue_pc0), n >= 1 ? 64'(mq[0].pc) : 64'h0);
      chk("uop1", bus.issue_uop1, n >= 2 ? mq[1].uop : 64'h0);
      chk("pc1", 64'(bus.issue_pc1), n >= 2 ? 64'(mq[1].pc) : 64'h0);
    end
  end
  task automatic step(input logic pv, input logic [3:0] m, input logic [27:0] pc, input logic [63:0] base,
                      input logic [1:0] ack, input logic fl);
    bus.pre_valid       = pv;
    bus.uop_4W_valid_in = m;
    bus.uop_4W_pc_in    = pc;
    bus.uop_4W_in       = {base + 64'd3, base + 64'd2, base + 64'd1, base};
    bus.issue_ack       = ack;
    bus.flush           = fl;
    @(negedge clk);
  endtask
  task automatic grp(input logic [3:0] m, input logic [1:0] ack);
    step(1'b1, m, 28'(g) << 4, 64'(g) << 8, ack, 1'b0);
    g++;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 4'hF, 28'h0, 64'hDEAD, 2'b11, 1'b0);
    rst = 1'b0;
  endtask
  initial begin
    bus.pre_valid = 1'b0;
    bus.uop_4W_valid_in = '0;
    bus.uop_4W_pc_in = '0;
    bus.uop_4W_in = '0;
    bus.issue_ack = '0;
    bus.flush = 1'b0;
    @(negedge clk);
    live = 1'b1;
    @(negedge clk);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ready", 64'(bus.out_ready), 64'd1);
    chk("rst_v0", 64'(bus.issue_valid0), 64'd0);
    chk("rst_v1", 64'(bus.issue_valid1), 64'd0);
    chk("rst_uop0", bus.issue_uop0, 64'd0);
    chk("rst_pc1", 64'(bus.issue_pc1), 64'd0);
    rst = 1'b0;
    step(1'b1, 4'hF, 28'h1C00000, 64'hA0, 2'b00, 1'b0);
    chk("g1_count", 64'(bus.count), 64'd4);
    chk("g1_uop0", bus.issue_uop0, 64'hA0);
    chk("g1_pc0", 64'(bus.issue_pc0), 64'h1C000000);
    chk("g1_uop1", bus.issue_uop1, 64'hA1);
    chk("g1_pc1", 64'(bus.issue_pc1), 64'h1C000004);
    step(1'b1, 4'b1100, 28'h1C00001, 64'hB0, 2'b00, 1'b0);
    chk("g2_count", 64'(bus.count), 64'd6);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b11, 1'b0);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b11, 1'b0);
    chk("g2_uop0", bus.issue_uop0, 64'hB2);
    chk("g2_pc0", 64'(bus.issue_pc0), 64'h1C000018);
    chk("g2_uop1", bus.issue_uop1, 64'hB3);
    chk("g2_pc1", 64'(bus.issue_pc1), 64'h1C00001C);
    step(1'b1, 4'b0001, 28'h1C00002, 64'hC0, 2'b00, 1'b0);
    chk("c3_count", 64'(bus.count), 64'd3);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b10, 1'b0);
    chk("ack10_count", 64'(bus.count), 64'd3);
    chk("ack10_uop0", bus.issue_uop0, 64'hB2);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b11, 1'b0);
    chk("c1_uop0", bus.issue_uop0, 64'hC0);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b11, 1'b0);
    chk("c0_count", 64'(bus.count), 64'd0);
    step(1'b1, 4'h0, 28'h1C00003, 64'hD0, 2'b00, 1'b0);
    chk("zero_mask_count", 64'(bus.count), 64'd0);
    repeat (4) grp(4'hF, 2'b00);
    chk("full_count", 64'(bus.count), 64'd16);
    chk("full_ready", 64'(bus.out_ready), 64'd0);
    repeat (3) grp(4'hF, 2'b01);
    chk("c13_count", 64'(bus.count), 64'd13);
    chk("c13_ready", 64'(bus.out_ready), 64'd0);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b01, 1'b0);
    chk("c12_ready", 64'(bus.out_ready), 64'd1);
    do_reset();
    chk("midrst_count", 64'(bus.count), 64'd0);
    chk("midrst_v0", 64'(bus.issue_valid0), 64'd0);
    repeat (3) grp(4'hF, 2'b00);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b01, 1'b0);
    repeat (12) grp(4'hF, 2'b11);
    for (int i = 0; i < 40; i++) begin
      bus.pre_valid = 1'($urandom_range(0, 3) != 0);
      grp(4'($urandom), 2'($urandom));
    end
    repeat (24) grp(4'hF, 2'b11);
    do_reset();
    repeat (2) grp(4'hF, 2'b00);
    grp(4'b0001, 2'b00);
    chk("pre_flush_count", 64'(bus.count), 64'd9);
    step(1'b1, 4'hF, 28'h1C00009, 64'hE0, 2'b11, 1'b1);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_v0", 64'(bus.issue_valid0), 64'd0);
    chk("flush_v1", 64'(bus.issue_valid1), 64'd0);
    chk("flush_ready", 64'(bus.out_ready), 64'd1);
    grp(4'b1010, 2'b00);
    step(1'b0, 4'h0, 28'h0, 64'h0, 2'b00, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
